// File: rtl/hash_arb_pkg.sv
// ============================================================================
// Module  : hash_arb_pkg
// Brief   : Shared types and constants for the hash core arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package hash_arb_pkg;

   localparam int c_len_w = 32;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_START   = 2'd1,
      S_BUSY    = 2'd2,
      S_RELEASE = 2'd3
   } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
// Module  : rr_pick
// Brief   : Combinational round-robin picker; searches from i_ptr+1 with wrap.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
   parameter int N  = 2,
   parameter int GW = $clog2(N)
) (
   input  logic [N-1:0]  i_req_vec,
   input  logic [GW-1:0] i_ptr,
   output logic [N-1:0]  o_grant_oh,
   output logic [GW-1:0] o_grant_idx,
   output logic          o_any_req
);

   logic [GW-1:0] w_cand;

   // Walk from the farthest candidate to the nearest so the nearest set bit wins.
   always_comb begin
      o_grant_oh  = '0;
      o_grant_idx = '0;
      o_any_req   = |i_req_vec;
      w_cand      = '0;
      for (int k = N; k >= 1; k--) begin
         w_cand = GW'((int'(i_ptr) + k) % N);
         if (i_req_vec[w_cand]) begin
            o_grant_oh         = '0;
            o_grant_oh[w_cand] = 1'b1;
            o_grant_idx        = w_cand;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/hash_core_arbiter.sv
// ============================================================================
// Module  : hash_core_arbiter
// Brief   : Round-robin sharing of one SHAKE-style hash core among N_REQ masters.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module hash_core_arbiter
   import hash_arb_pkg::*;
#(
   parameter int N_REQ  = 2,
   parameter int ADDR_W = 3,
   parameter int GW     = $clog2(N_REQ)
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic [N_REQ-1:0]          i_req_start,
   input  logic [c_len_w*N_REQ-1:0]  i_req_input_length,
   input  logic [c_len_w*N_REQ-1:0]  i_req_output_length,
   input  logic [c_len_w*N_REQ-1:0]  i_req_data_in,
   output logic [ADDR_W-1:0]         o_req_addr,
   output logic [N_REQ-1:0]          o_req_rd_en,
   output logic [c_len_w-1:0]        o_req_data_out,
   output logic [N_REQ-1:0]          o_req_data_out_valid,
   input  logic [N_REQ-1:0]          i_req_data_out_ready,
   input  logic [N_REQ-1:0]          i_req_force_done,
   output logic [N_REQ-1:0]          o_req_force_done_ack,
   output logic [N_REQ-1:0]          o_grant,
   output logic                      o_hash_start,
   output logic [c_len_w-1:0]        o_hash_input_length,
   output logic [c_len_w-1:0]        o_hash_output_length,
   output logic [c_len_w-1:0]        o_hash_data_in,
   input  logic [ADDR_W-1:0]         i_hash_addr,
   input  logic                      i_hash_rd_en,
   input  logic [c_len_w-1:0]        i_hash_data_out,
   input  logic                      i_hash_data_out_valid,
   output logic                      o_hash_data_out_ready,
   output logic                      o_hash_force_done,
   input  logic                      i_hash_force_done_ack
);

   arb_state_t          r_state, w_state_nx;
   logic [N_REQ-1:0]    r_pending, w_pending_nx;
   logic [N_REQ-1:0]    r_grant, w_grant_nx;
   logic [N_REQ-1:0]    r_req_ack, w_req_ack_nx;
   logic [GW-1:0]       r_gidx, w_gidx_nx;
   logic [GW-1:0]       r_rr_ptr, w_rr_ptr_nx;
   logic [c_len_w-1:0]  r_in_len, w_in_len_nx;
   logic [c_len_w-1:0]  r_out_len, w_out_len_nx;

   logic [N_REQ-1:0]    w_req_vec;
   logic [N_REQ-1:0]    w_pick_oh;
   logic [GW-1:0]       w_pick_idx;
   logic                w_pick_any;
   logic                w_busy;

   assign w_req_vec = r_pending | i_req_start;

   rr_pick #(
      .N  (N_REQ),
      .GW (GW)
   ) u_rr_pick (
      .i_req_vec   (w_req_vec),
      .i_ptr       (r_rr_ptr),
      .o_grant_oh  (w_pick_oh),
      .o_grant_idx (w_pick_idx),
      .o_any_req   (w_pick_any)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state   <= S_IDLE;
         r_pending <= '0;
         r_grant   <= '0;
         r_req_ack <= '0;
         r_gidx    <= '0;
         r_rr_ptr  <= GW'(N_REQ - 1);
         r_in_len  <= '0;
         r_out_len <= '0;
      end else begin
         r_state   <= w_state_nx;
         r_pending <= w_pending_nx;
         r_grant   <= w_grant_nx;
         r_req_ack <= w_req_ack_nx;
         r_gidx    <= w_gidx_nx;
         r_rr_ptr  <= w_rr_ptr_nx;
         r_in_len  <= w_in_len_nx;
         r_out_len <= w_out_len_nx;
      end
   end

   always_comb begin
      w_state_nx   = r_state;
      w_pending_nx = w_req_vec;
      w_grant_nx   = r_grant;
      w_req_ack_nx = '0;
      w_gidx_nx    = r_gidx;
      w_rr_ptr_nx  = r_rr_ptr;
      w_in_len_nx  = r_in_len;
      w_out_len_nx = r_out_len;
      case (r_state)
         S_IDLE: begin
            if (w_pick_any) begin
               // A start arriving in the grant cycle folds into this grant.
               w_state_nx   = S_START;
               w_pending_nx = w_req_vec & ~w_pick_oh;
               w_grant_nx   = w_pick_oh;
               w_gidx_nx    = w_pick_idx;
               w_rr_ptr_nx  = w_pick_idx;
               w_in_len_nx  = i_req_input_length[w_pick_idx*c_len_w +: c_len_w];
               w_out_len_nx = i_req_output_length[w_pick_idx*c_len_w +: c_len_w];
            end
         end
         S_START: w_state_nx = S_BUSY;
         S_BUSY: begin
            if (i_req_force_done[r_gidx]) w_state_nx = S_RELEASE;
         end
         S_RELEASE: begin
            if (i_hash_force_done_ack) begin
               w_state_nx   = S_IDLE;
               w_grant_nx   = '0;
               w_req_ack_nx = r_grant;
               w_in_len_nx  = '0;
               w_out_len_nx = '0;
            end
         end
         default: w_state_nx = S_IDLE;
      endcase
   end

   // Routing is purely combinational and only open while the core is busy.
   assign w_busy = (r_state == S_BUSY);

   assign o_grant              = r_grant;
   assign o_req_force_done_ack = r_req_ack;
   assign o_hash_start         = (r_state == S_START);
   assign o_hash_force_done    = (r_state == S_RELEASE);
   assign o_hash_input_length  = r_in_len;
   assign o_hash_output_length = r_out_len;

   assign o_req_addr            = w_busy ? i_hash_addr : '0;
   assign o_req_rd_en           = (w_busy && i_hash_rd_en) ? r_grant : '0;
   assign o_hash_data_in        = w_busy ? i_req_data_in[r_gidx*c_len_w +: c_len_w] : '0;
   assign o_req_data_out        = w_busy ? i_hash_data_out : '0;
   assign o_req_data_out_valid  = (w_busy && i_hash_data_out_valid) ? r_grant : '0;
   assign o_hash_data_out_ready = w_busy && i_req_data_out_ready[r_gidx];

endmodule

`default_nettype wire

// File: tb/tb_hash_core_arbiter.sv
// ============================================================================
// Module  : tb_hash_core_arbiter
// Brief   : Directed self-checking bench for hash_core_arbiter (N_REQ=2).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hash_core_arbiter;

   localparam int N_REQ  = 2;
   localparam int ADDR_W = 3;

   logic              clk;
   logic              rst;
   logic [1:0]        i_req_start;
   logic [63:0]       i_req_input_length;
   logic [63:0]       i_req_output_length;
   logic [63:0]       i_req_data_in;
   logic [2:0]        o_req_addr;
   logic [1:0]        o_req_rd_en;
   logic [31:0]       o_req_data_out;
   logic [1:0]        o_req_data_out_valid;
   logic [1:0]        i_req_data_out_ready;
   logic [1:0]        i_req_force_done;
   logic [1:0]        o_req_force_done_ack;
   logic [1:0]        o_grant;
   logic              o_hash_start;
   logic [31:0]       o_hash_input_length;
   logic [31:0]       o_hash_output_length;
   logic [31:0]       o_hash_data_in;
   logic [2:0]        i_hash_addr;
   logic              i_hash_rd_en;
   logic [31:0]       i_hash_data_out;
   logic              i_hash_data_out_valid;
   logic              o_hash_data_out_ready;
   logic              o_hash_force_done;
   logic              i_hash_force_done_ack;

   int n_cmp = 0;
   int n_err = 0;

   hash_core_arbiter #(
      .N_REQ  (N_REQ),
      .ADDR_W (ADDR_W)
   ) dut (
      .i_clk                 (clk),
      .i_rst                 (rst),
      .i_req_start           (i_req_start),
      .i_req_input_length    (i_req_input_length),
      .i_req_output_length   (i_req_output_length),
      .i_req_data_in         (i_req_data_in),
      .o_req_addr            (o_req_addr),
      .o_req_rd_en           (o_req_rd_en),
      .o_req_data_out        (o_req_data_out),
      .o_req_data_out_valid  (o_req_data_out_valid),
      .i_req_data_out_ready  (i_req_data_out_ready),
      .i_req_force_done      (i_req_force_done),
      .o_req_force_done_ack  (o_req_force_done_ack),
      .o_grant               (o_grant),
      .o_hash_start          (o_hash_start),
      .o_hash_input_length   (o_hash_input_length),
      .o_hash_output_length  (o_hash_output_length),
      .o_hash_data_in        (o_hash_data_in),
      .i_hash_addr           (i_hash_addr),
      .i_hash_rd_en          (i_hash_rd_en),
      .i_hash_data_out       (i_hash_data_out),
      .i_hash_data_out_valid (i_hash_data_out_valid),
      .o_hash_data_out_ready (o_hash_data_out_ready),
      .o_hash_force_done     (o_hash_force_done),
      .i_hash_force_done_ack (i_hash_force_done_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Waits for the grant to the expected owner, then releases it with an immediate ack.
   task automatic run_job(input string tag, input logic [1:0] exp_g);
      int n = 0;
      while (o_hash_start !== 1'b1 && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_start"}, 32'(o_hash_start), 32'd1);
      chk({tag, "_grant"}, 32'(o_grant), 32'(exp_g));
      @(negedge clk);
      i_req_force_done = exp_g;
      @(negedge clk);
      i_req_force_done = 2'b00;
      i_hash_force_done_ack = 1'b1;
      @(negedge clk);
      i_hash_force_done_ack = 1'b0;
      chk({tag, "_ack"}, 32'(o_req_force_done_ack), 32'(exp_g));
   endtask

   initial begin
      rst                   = 1'b1;
      i_req_start           = '0;
      i_req_input_length    = {32'd512, 32'd256};
      i_req_output_length   = {32'd64, 32'd136};
      i_req_data_in         = '0;
      i_req_data_out_ready  = '0;
      i_req_force_done      = '0;
      i_hash_addr           = '0;
      i_hash_rd_en          = 1'b0;
      i_hash_data_out       = '0;
      i_hash_data_out_valid = 1'b0;
      i_hash_force_done_ack = 1'b0;
      repeat (3) @(negedge clk);

      chk("rst_grant", 32'(o_grant), 32'd0);
      chk("rst_start", 32'(o_hash_start), 32'd0);
      chk("rst_fdone", 32'(o_hash_force_done), 32'd0);
      chk("rst_ack", 32'(o_req_force_done_ack), 32'd0);
      chk("rst_inlen", o_hash_input_length, 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Single request from req0
      i_req_start = 2'b01;
      @(negedge clk);
      i_req_start = 2'b00;
      chk("single_grant", 32'(o_grant), 32'd1);
      chk("single_start", 32'(o_hash_start), 32'd1);
      chk("single_inlen", o_hash_input_length, 32'd256);
      chk("single_outlen", o_hash_output_length, 32'd136);
      @(negedge clk);
      chk("single_start_once", 32'(o_hash_start), 32'd0);

      // Stray release from a non-owner
      i_req_force_done = 2'b10;
      @(negedge clk);
      i_req_force_done = 2'b00;
      chk("stray_fdone", 32'(o_hash_force_done), 32'd0);
      chk("stray_grant", 32'(o_grant), 32'd1);

      // Release with the core ack delayed; force_done stays high for 4 cycles
      i_req_force_done      = 2'b01;
      i_req_data_out_ready  = 2'b11;
      i_hash_data_out_valid = 1'b1;
      @(negedge clk);
      i_req_force_done = 2'b00;
      for (int c = 0; c < 4; c++) begin
         chk($sformatf("rel_fdone_%0d", c), 32'(o_hash_force_done), 32'd1);
         if (c == 0) begin
            chk("rel_ready_off", 32'(o_hash_data_out_ready), 32'd0);
            chk("rel_valid_off", 32'(o_req_data_out_valid), 32'd0);
            chk("rel_no_start", 32'(o_hash_start), 32'd0);
         end
         if (c == 3) i_hash_force_done_ack = 1'b1;
         @(negedge clk);
      end
      i_hash_force_done_ack = 1'b0;
      chk("rel_ack", 32'(o_req_force_done_ack), 32'd1);
      chk("rel_grant_clr", 32'(o_grant), 32'd0);
      chk("rel_fdone_clr", 32'(o_hash_force_done), 32'd0);
      @(negedge clk);
      chk("rel_ack_pulse", 32'(o_req_force_done_ack), 32'd0);
      i_hash_data_out_valid = 1'b0;
      i_req_data_out_ready  = 2'b00;

      // Simultaneous starts: req0 first, req1 served from pending
      do_reset();
      i_req_start = 2'b11;
      @(negedge clk);
      i_req_start = 2'b00;
      chk("sim_grant0", 32'(o_grant), 32'd1);
      chk("sim_start0", 32'(o_hash_start), 32'd1);
      @(negedge clk);
      i_req_force_done = 2'b01;
      @(negedge clk);
      i_req_force_done      = 2'b00;
      i_hash_force_done_ack = 1'b1;
      chk("sim_fdone", 32'(o_hash_force_done), 32'd1);
      @(negedge clk);
      i_hash_force_done_ack = 1'b0;
      chk("sim_ack0", 32'(o_req_force_done_ack), 32'd1);
      chk("sim_idle_grant", 32'(o_grant), 32'd0);
      chk("sim_idle_start", 32'(o_hash_start), 32'd0);
      @(negedge clk);
      chk("sim_grant1", 32'(o_grant), 32'd2);
      chk("sim_start1", 32'(o_hash_start), 32'd1);
      chk("sim_inlen1", o_hash_input_length, 32'd512);
      chk("sim_outlen1", o_hash_output_length, 32'd64);
      @(negedge clk);

      // Read path routed to req1 in the same cycle
      for (int a = 0; a < 8; a++) begin
         i_hash_addr   = 3'(a);
         i_hash_rd_en  = 1'b1;
         i_req_data_in = {32'hA0 + 32'(a), 32'h50 + 32'(a)};
         #1;
         chk($sformatf("rd_data_%0d", a), o_hash_data_in, 32'hA0 + 32'(a));
         chk($sformatf("rd_addr_%0d", a), 32'(o_req_addr), 32'(a));
         chk($sformatf("rd_en_%0d", a), 32'(o_req_rd_en), 32'd2);
         @(negedge clk);
      end
      i_hash_rd_en = 1'b0;

      // Output path: req1 holds ready low for 3 cycles
      i_req_data_out_ready  = 2'b01;
      i_hash_data_out_valid = 1'b1;
      i_hash_data_out       = 32'hDEAD0001;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk($sformatf("bp_ready_%0d", c), 32'(o_hash_data_out_ready), 32'd0);
         chk($sformatf("bp_valid_%0d", c), 32'(o_req_data_out_valid), 32'd2);
         chk($sformatf("bp_data_%0d", c), o_req_data_out, 32'hDEAD0001);
         @(negedge clk);
      end
      i_req_data_out_ready = 2'b10;
      #1;
      chk("bp_ready_on", 32'(o_hash_data_out_ready), 32'd1);
      chk("bp_valid_on", 32'(o_req_data_out_valid), 32'd2);
      @(negedge clk);
      i_hash_data_out_valid = 1'b0;
      i_req_data_out_ready  = 2'b00;
      i_req_force_done      = 2'b10;
      @(negedge clk);
      i_req_force_done      = 2'b00;
      i_hash_force_done_ack = 1'b1;
      @(negedge clk);
      i_hash_force_done_ack = 1'b0;
      chk("dp_ack1", 32'(o_req_force_done_ack), 32'd2);

      // Round robin with both requesters restarting continuously
      do_reset();
      i_req_start = 2'b11;
      run_job("rr0", 2'b01);
      run_job("rr1", 2'b10);
      run_job("rr2", 2'b01);
      run_job("rr3", 2'b10);
      i_req_start = 2'b00;

      // Reset while busy with req1 pending
      do_reset();
      i_req_start = 2'b01;
      @(negedge clk);
      i_req_start = 2'b00;
      @(negedge clk);
      i_req_start = 2'b10;
      @(negedge clk);
      i_req_start           = 2'b00;
      i_hash_data_out_valid = 1'b1;
      i_req_data_out_ready  = 2'b11;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst_grant", 32'(o_grant), 32'd0);
      chk("mid_rst_valid", 32'(o_req_data_out_valid), 32'd0);
      chk("mid_rst_data", o_req_data_out, 32'd0);
      chk("mid_rst_ready", 32'(o_hash_data_out_ready), 32'd0);
      chk("mid_rst_fdone", 32'(o_hash_force_done), 32'd0);
      chk("mid_rst_inlen", o_hash_input_length, 32'd0);
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         chk($sformatf("mid_rst_nostart_%0d", c), 32'(o_hash_start), 32'd0);
         chk($sformatf("mid_rst_nogrant_%0d", c), 32'(o_grant), 32'd0);
      end
      i_hash_data_out_valid = 1'b0;
      i_req_data_out_ready  = 2'b00;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/hash_core_arbiter.md
Name: hash_core_arbiter

Overview:
- Shares one hash core (SHAKE-style: start, input-length/output-length, address-driven input read, valid/ready output stream, force-done/ack) among N_REQ signing sub-blocks, e.g. view-challenge expansion and commitment generation.
- Each requester keeps its native hash-master interface. The arbiter latches start requests, grants round-robin, and routes the core's read and output paths to the grantee.
- It holds the grant until the grantee's force-done is acknowledged by the core.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- ADDR_W, 3, width of the core input-read address.
- GW, `CLOG2(N_REQ), width of the grant index.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- i_req_start  in  N_REQ  per-requester 1-cycle start pulse.
- i_req_input_length  in  32*N_REQ  per-requester input length in bits; slice r = [32r+31:32r].
- i_req_output_length  in  32*N_REQ  per-requester output length in bits.
- i_req_data_in  in  32*N_REQ  requester message-memory read data.
- o_req_addr  out  ADDR_W  core read address, broadcast to all requesters.
- o_req_rd_en  out  N_REQ  core read enable, grantee bit only.
- o_req_data_out  out  32  core output word, broadcast.
- o_req_data_out_valid  out  N_REQ  output valid, grantee bit only.
- i_req_data_out_ready  in  N_REQ  per-requester output ready.
- i_req_force_done  in  N_REQ  per-requester release pulse.
- o_req_force_done_ack  out  N_REQ  1-cycle release acknowledge.
- o_grant  out  N_REQ  one-hot current owner; 0 when idle.
- o_hash_start  out  1  core start.
- o_hash_input_length  out  32  latched length of grantee.
- o_hash_output_length  out  32  latched length of grantee.
- o_hash_data_in  out  32  muxed i_req_data_in of grantee.
- i_hash_addr  in  ADDR_W  core read address.
- i_hash_rd_en  in  1  core read enable.
- i_hash_data_out  in  32  core output word.
- i_hash_data_out_valid  in  1  core output valid.
- o_hash_data_out_ready  out  1  core output ready.
- o_hash_force_done  out  1  core release request.
- i_hash_force_done_ack  in  1  core release acknowledge.

Behaviour:
- Reset: state S_IDLE; pending=0; o_grant=0; rr_ptr=N_REQ-1 (requester 0 has first priority); len regs=0; o_hash_start=0; o_hash_force_done=0; o_req_force_done_ack=0. All routed outputs are 0 when no grant.
- Pending register: pending[r] is set by i_req_start[r] in any state. It is cleared when r is granted. A start from r in the cycle r is granted merges into that grant (single request).
- S_IDLE:
  - req_vec = pending | i_req_start.
  - If nonzero, pick the first set bit searching from rr_ptr+1 with wrap.
  - Register grant index g, o_grant, and both lengths of g; set rr_ptr=g; go to S_START.
- S_START: o_hash_start=1 for exactly one cycle; go to S_BUSY. Start sampled in cycle t with the arbiter idle gives o_hash_start high in cycle t+1.
- S_BUSY (combinational routing, zero added latency):
  - o_req_addr=i_hash_addr; o_req_rd_en[g]=i_hash_rd_en; o_hash_data_in=i_req_data_in[g].
  - o_req_data_out=i_hash_data_out; o_req_data_out_valid[g]=i_hash_data_out_valid; o_hash_data_out_ready=i_req_data_out_ready[g].
  - On i_req_force_done[g], go to S_RELEASE. force_done from non-grantees is ignored.
- S_RELEASE:
  - o_hash_force_done=1 (registered level); output ready=0; routing disabled.
  - On i_hash_force_done_ack: pulse o_req_force_done_ack[g] for 1 cycle, drop o_hash_force_done, clear o_grant, go to S_IDLE.
  - An ack arriving in the same cycle force_done is first driven is accepted.
- Ownership: a grantee's own start pulse while busy sets pending[g]; it is served after release, in round-robin order.
- Reset mid-operation: all pending and in-flight grants are dropped. Requesters must be reset together with the arbiter.
- Invariants: o_grant is one-hot or 0; o_hash_start never fires while o_hash_force_done=1; no valid is routed outside S_BUSY.

Decomposition:
- Package hash_arb_pkg: state encoding (S_IDLE=0, S_START=1, S_BUSY=2, S_RELEASE=3) and the length-word width constant 32.
- Sub-module rr_pick: combinational round-robin picker (req_vec, ptr -> one-hot grant plus index, any_req). It is reused by other shared-resource arbiters.

Test Plan:
- Single request: start on req0 at cycle 5 -> o_grant=01, o_hash_start at cycle 6, lengths equal req0 values (256, 136).
- Simultaneous starts req0 and req1 from reset -> req0 served first. After ack, req1 is granted with no extra request, and o_hash_start fires 2 cycles after the req0 ack.
- Round robin: both requesters restart continuously -> grants alternate 0,1,0,1 over 4 jobs.
- Data path: core reads addr 0..7 and req1 memory returns 0xA0..0xA7 -> o_hash_data_in matches in the same cycle. With ready held low 3 cycles, valid words are not lost and o_hash_data_out_ready mirrors req1.
- Release: req0 force_done, core ack delayed 4 cycles -> o_hash_force_done high 4 cycles, single ack pulse to req0, o_grant=0 next cycle. Stray force_done from req1 has no effect.
- Reset in S_BUSY with req1 pending -> all outputs 0 next cycle, pending cleared, and no grant is issued afterwards.
